// File: rtl/top_module_display.sv
// Fibonacci generator that steps once per TICK_DIV clocks and shows the current
// value on five active-low 7-segment digits, with leading zeros blanked.
module top_module_display #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] hex_4,
  output logic [6:0] hex_3,
  output logic [6:0] hex_2,
  output logic [6:0] hex_1,
  output logic [6:0] hex_0
);

  localparam logic [25:0] TICK_LAST  = 26'(TICK_DIV - 1);
  localparam logic [16:0] WRAP_LIMIT = 17'd99999;
  localparam logic [6:0]  SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]  SEG_ZERO   = 7'b1000000;

  function automatic logic [6:0] seg7(input logic [3:0] value);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (value)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Step-rate divider
  logic [25:0] count_reg, count_next;
  logic        tick;

  always_comb begin
    tick       = (count_reg == TICK_LAST);
    count_next = tick ? 26'd0 : count_reg + 26'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_reg <= 26'd0;
    else       count_reg <= count_next;
  end

  // Generator pair: a is displayed, b is the next term.
  logic [16:0] a_reg, a_next;
  logic [16:0] b_reg, b_next;

  always_comb begin
    a_next = a_reg;
    b_next = b_reg;
    if (tick) begin
      if (b_reg > WRAP_LIMIT) begin
        a_next = 17'd0;
        b_next = 17'd1;
      end else begin
        // Only taken while b <= 99999, so the sum stays below 2^17.
        a_next = b_reg;
        b_next = a_reg + b_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg <= 17'd0;
      b_reg <= 17'd1;
    end else begin
      a_reg <= a_next;
      b_reg <= b_next;
    end
  end

  // Double-dabble; a never exceeds 99999 so five BCD digits suffice.
  logic [19:0] bcd;

  always_comb begin
    bcd = 20'd0;
    for (int i = 16; i >= 0; i--) begin
      for (int d = 0; d < 5; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[18:0], a_reg[i]};
    end
  end

  logic [3:0] digit [5];
  logic [5:1] lead_zero;
  logic [6:0] hex_out [5];

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_digit
      localparam logic [6:0] SEG_RESET = (gi == 0) ? SEG_ZERO : SEG_BLANK;
      logic [6:0] seg_reg, seg_next;

      assign digit[gi] = bcd[gi*4 +: 4];

      // lead_zero[i]: digit i and every digit above it are zero.
      if (gi == 4) begin : g_top
        assign lead_zero[gi] = (digit[gi] == 4'd0);
      end else if (gi > 0) begin : g_mid
        assign lead_zero[gi] = lead_zero[gi+1] & (digit[gi] == 4'd0);
      end

      if (gi == 0) begin : g_units
        assign seg_next = seg7(digit[gi]);
      end else begin : g_upper
        assign seg_next = lead_zero[gi] ? SEG_BLANK : seg7(digit[gi]);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) seg_reg <= SEG_RESET;
        else       seg_reg <= seg_next;
      end

      assign hex_out[gi] = seg_reg;
    end
  endgenerate

  assign hex_0 = hex_out[0];
  assign hex_1 = hex_out[1];
  assign hex_2 = hex_out[2];
  assign hex_3 = hex_out[3];
  assign hex_4 = hex_out[4];

endmodule

// File: tb/tb_top_module_display.sv
// Directed bench for top_module_display: one instance stepping every 4 clocks,
// one stepping every clock, checked against a Fibonacci table and digit model.
module tb_top_module_display;

  localparam logic [6:0] S_BLANK = 7'b1111111;
  localparam logic [6:0] SEG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  // Value of a after k ticks, including the wrap at tick 26.
  localparam int FIB [28] = '{
    0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987,
    1597, 2584, 4181, 6765, 10946, 17711, 28657, 46368, 75025, 0, 1
  };

  logic       clk;
  logic       rst4, rst1;
  logic [6:0] p4_h4, p4_h3, p4_h2, p4_h1, p4_h0;
  logic [6:0] p1_h4, p1_h3, p1_h2, p1_h1, p1_h0;

  int vectors = 0;
  int miscompares = 0;

  top_module_display #(.TICK_DIV(4)) u_div4 (
    .clk(clk), .reset(rst4),
    .hex_4(p4_h4), .hex_3(p4_h3), .hex_2(p4_h2), .hex_1(p4_h1), .hex_0(p4_h0)
  );

  top_module_display #(.TICK_DIV(1)) u_div1 (
    .clk(clk), .reset(rst1),
    .hex_4(p1_h4), .hex_3(p1_h3), .hex_2(p1_h2), .hex_1(p1_h1), .hex_0(p1_h0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected five-digit pattern for a decimal value, with leading-zero blanking.
  task automatic chk_value(input string tag, input int value,
                           input logic [6:0] h4, input logic [6:0] h3,
                           input logic [6:0] h2, input logic [6:0] h1,
                           input logic [6:0] h0);
    logic [6:0] exp [5];
    logic [6:0] obs [5];
    int  dig;
    int  div;
    bit  lead;
    obs[4] = h4; obs[3] = h3; obs[2] = h2; obs[1] = h1; obs[0] = h0;
    lead = 1'b1;
    div  = 10000;
    for (int i = 4; i >= 0; i--) begin
      dig  = (value / div) % 10;
      lead = lead && (dig == 0);
      exp[i] = (lead && i != 0) ? S_BLANK : SEG[dig];
      div = div / 10;
    end
    for (int i = 4; i >= 0; i--) chk($sformatf("%s hex_%0d (value %0d)", tag, i, value), obs[i], exp[i]);
  endtask

  initial begin
    rst4 = 1'b1;
    rst1 = 1'b1;

    // Reset held over several clocks
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst4 clk%0d hex_0", c), p4_h0, 7'b1000000);
      chk($sformatf("rst4 clk%0d hex_4", c), p4_h4, S_BLANK);
      chk($sformatf("rst4 clk%0d hex_1", c), p4_h1, S_BLANK);
      chk($sformatf("rst1 clk%0d hex_0", c), p1_h0, 7'b1000000);
    end

    // TICK_DIV=4: display after edge e shows F((e-1)/4)
    rst4 = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk_value($sformatf("div4 edge%0d", e), FIB[(e - 1) / 4], p4_h4, p4_h3, p4_h2, p4_h1, p4_h0);
      if (e == 4)  chk("div4 edge4 still 0", p4_h0, 7'b1000000);
      if (e == 5)  chk("div4 edge5 first 1", p4_h0, 7'b1111001);
      if (e == 13) chk("div4 tick3 shows 2", p4_h0, 7'b0100100);
    end

    // TICK_DIV=1: display after edge e shows F(e-1)
    rst1 = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk_value($sformatf("div1 edge%0d", e), FIB[e - 1], p1_h4, p1_h3, p1_h2, p1_h1, p1_h0);
    end
    chk("13 hex_1", p1_h1, 7'b1111001);
    chk("13 hex_0", p1_h0, 7'b0110000);
    chk("13 hex_2 blank", p1_h2, S_BLANK);

    // Asynchronous reset between edges
    #1 rst1 = 1'b1;
    #1;
    chk("async rst hex_0", p1_h0, 7'b1000000);
    chk("async rst hex_1", p1_h1, S_BLANK);
    @(negedge clk);
    chk("held rst hex_0", p1_h0, 7'b1000000);
    rst1 = 1'b0;

    for (int e = 1; e <= 28; e++) begin
      @(posedge clk);
      @(negedge clk);
      chk_value($sformatf("restart edge%0d", e), FIB[e - 1], p1_h4, p1_h3, p1_h2, p1_h1, p1_h0);
      if (e == 26) begin
        chk("75025 hex_4", p1_h4, 7'b1111000);
        chk("75025 hex_3", p1_h3, 7'b0010010);
        chk("75025 hex_2", p1_h2, 7'b1000000);
        chk("75025 hex_1", p1_h1, 7'b0100100);
        chk("75025 hex_0", p1_h0, 7'b0010010);
      end
      if (e == 27) begin
        chk("wrap hex_0", p1_h0, 7'b1000000);
        chk("wrap hex_4", p1_h4, S_BLANK);
        chk("wrap hex_1", p1_h1, S_BLANK);
      end
      if (e == 28) chk("after wrap hex_0", p1_h0, 7'b1111001);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
